dtim_pipelined: RTL and testbench
=================================

Name: dtim_pipelined

Overview:
Parametrised data tightly-integrated memory (DTIM) for the core's load/store unit, replacing the fixed 1024x32 single-port DTIM. Adds a valid/ready request channel and a response channel with backpressure, sized by a credit counter and a small fall-through response FIFO. Supports byte-lane writes, out-of-range error reporting and an optional output register stage. Sits between the LSU and the data-side address decoder.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DEPTH_WORDS, 1024, number of words; need not be a power of two.
ADDR_WIDTH, 14, byte-address width of req_addr.
OUT_REG, 0, 1 adds a registered stage after the memory read port.
RESP_DEPTH, 2, maximum outstanding responses (pipeline plus FIFO); range 1..8.
INIT_FILE, "NONE", hex file loaded with $readmemh at elaboration when not "NONE".

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-low (asserted when 0).
req_valid  in  1  request present.
req_ready  out  1  request can be accepted.
req_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
req_wmask  in  DATA_WIDTH/8  byte write enables; all zero means read.
req_wdata  in  DATA_WIDTH  write data, lane-aligned.
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  DATA_WIDTH  word read; for writes, the post-write word (write-first).
resp_err  out  1  word index >= DEPTH_WORDS.

Behaviour:
- A request is accepted on a rising edge when req_valid & req_ready. A response is popped on a rising edge when resp_valid & resp_ready.
- Reset (rst==0 at an edge): used counter=0, pipeline valid bits=0, FIFO empty, resp_valid=0, resp_err=0, resp_rdata=0.
  - req_ready=0 while rst==0; it reflects the credit state from the first cycle after release.
  - Memory contents are not reset.
- Mid-operation reset discards all in-flight requests and responses. A write already clocked into the array before reset stays.
- Credit counter `used` (0..RESP_DEPTH):
  - +1 on accept only; -1 on pop only; unchanged when both or neither occur.
  - req_ready = (used < RESP_DEPTH), driven from registered state only; there is no combinational path from resp_ready to req_ready.
- Memory stage, at the accept edge:
  - Index = req_addr >> log2(DATA_WIDTH/8).
  - If index is in range: write enabled lanes; read the same index write-first (unmasked lanes return old data).
  - If index is out of range: no write; rdata forced to 0; err=1.
- Optional stage: when OUT_REG=1, data, err and valid pass through one extra register.
- Response path, fall-through FIFO of depth RESP_DEPTH:
  - Pipeline output goes straight to resp_* when the FIFO is empty; otherwise it is pushed into the FIFO.
  - The FIFO head is always older than the pipeline output, so order is preserved.
  - A pipeline output not popped in its cycle is pushed into the FIFO.
  - resp_valid = FIFO non-empty | pipeline output valid.
- Latency: accept at edge k gives resp_valid in cycle k+1+OUT_REG when the FIFO is empty. Responses stay stable while resp_valid & !resp_ready.
- Throughput: one request per cycle sustained when resp_ready=1 and RESP_DEPTH >= 1+OUT_REG+1.
- Boundaries:
  - The credit scheme guarantees the FIFO never overflows; an overflow or underflow is an assertion failure.
  - The last word (DEPTH_WORDS-1) is valid; index DEPTH_WORDS is an error.
  - Any req_addr bits above the index are included in the range check, not wrapped.

Decomposition:
- Package dtim_pkg: localparams BYTES=DATA_WIDTH/8, OFFS_W=$clog2(BYTES), IDX_W=$clog2(DEPTH_WORDS), CNT_W=$clog2(RESP_DEPTH+1); a response record {err, rdata} packed-width constant.
- Sub-module dtim_resp_fifo: parametrised fall-through FIFO (width DATA_WIDTH+1, depth RESP_DEPTH) with push/pop/empty/full. The memory array is inferred in the top level as a byte-enabled RAM.

Test Plan:
- Write addr 0x010, wmask 4'hF, wdata 0xDEADBEEF, then read 0x010 -> write response rdata 0xDEADBEEF err 0; read response 0xDEADBEEF one cycle after accept (OUT_REG=0).
- Preload 0x11223344 at 0x020; write wmask 4'b0100, wdata 0x00AA0000 -> response and later read both 0x11AA3344.
- resp_ready=0, req_valid=1 continuously, RESP_DEPTH=2 -> exactly 2 accepts, then req_ready=0. Raise resp_ready -> responses in order, one per cycle, and req_ready returns the cycle after the first pop.
- Read index DEPTH_WORDS (byte 0x1000) and write there -> err=1, rdata 0, and word 0 is unchanged on readback. Index 1023 -> err=0.
- OUT_REG=1, RESP_DEPTH=3, back-to-back reads of 4 addresses -> resp_valid first at k+2, then one response per cycle with no bubbles.
- rst=0 for one cycle with 2 responses outstanding -> resp_valid=0 next cycle; used=0 so req_ready=1 after release; a write accepted before reset reads back correctly.

Source files
------------

// File: rtl/dtim_pkg.sv
// Shared helpers for the pipelined DTIM: index-width sizing and the response record width.
package dtim_pkg;

  // Width needed to index n entries; never returns 0 so that single-entry arrays stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Packed response record is {err, rdata}.
  function automatic int unsigned resp_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/dtim_resp_fifo.sv
// Fall-through response FIFO: the head entry is visible on o_rdata whenever o_empty is low.
module dtim_resp_fifo import dtim_pkg::*; #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (32'(r_count) == DEPTH);
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && o_full));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && o_empty));

endmodule

// File: rtl/dtim_pipelined.sv
// Data TIM with valid/ready request channel, credit-limited outstanding responses,
// byte-lane writes (write-first read), out-of-range error and optional output register.
module dtim_pipelined import dtim_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned RESP_DEPTH  = 2,
  parameter              INIT_FILE   = "NONE"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);
  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = clog2_min1(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned WORD_W = ADDR_WIDTH - OFFS_W;
  localparam int unsigned RESP_W = resp_w(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [WORD_W-1:0]     w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_new;
  logic [CNT_W-1:0]      r_used;

  // Upper address bits stay in the range check so aliases above the array report an error.
  assign w_word     = req_addr[ADDR_WIDTH-1:OFFS_W];
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_in_range = (32'(w_word) < DEPTH_WORDS);

  assign req_ready = rst && (32'(r_used) < RESP_DEPTH);
  assign w_accept  = req_valid && req_ready;
  assign w_pop     = resp_valid && resp_ready;

  assign w_old = r_mem[w_idx];
  always_comb begin
    w_new = w_old;
    for (int b = 0; b < BYTES; b++) begin
      if (req_wmask[b]) w_new[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_accept && w_in_range && req_wmask[b]) r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_used <= '0;
    end else if (w_accept && !w_pop) begin
      r_used <= r_used + 1'b1;
    end else if (!w_accept && w_pop) begin
      r_used <= r_used - 1'b1;
    end
  end

  logic                  r_s0_valid;
  logic                  r_s0_err;
  logic [DATA_WIDTH-1:0] r_s0_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s0_valid <= 1'b0;
      r_s0_err   <= 1'b0;
      r_s0_rdata <= '0;
    end else begin
      r_s0_valid <= w_accept;
      if (w_accept) begin
        r_s0_err   <= !w_in_range;
        r_s0_rdata <= w_in_range ? w_new : '0;
      end
    end
  end

  logic                  w_po_valid;
  logic                  w_po_err;
  logic [DATA_WIDTH-1:0] w_po_rdata;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_rdata;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_s1_valid <= 1'b0;
        r_s1_err   <= 1'b0;
        r_s1_rdata <= '0;
      end else begin
        r_s1_valid <= r_s0_valid;
        r_s1_err   <= r_s0_err;
        r_s1_rdata <= r_s0_rdata;
      end
    end

    assign w_po_valid = r_s1_valid;
    assign w_po_err   = r_s1_err;
    assign w_po_rdata = r_s1_rdata;
  end else begin : g_no_out_reg
    assign w_po_valid = r_s0_valid;
    assign w_po_err   = r_s0_err;
    assign w_po_rdata = r_s0_rdata;
  end

  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [RESP_W-1:0] w_fifo_head;

  // Pipeline output bypasses the FIFO only when nothing older is queued and it is taken now.
  assign w_fifo_push = w_po_valid && !(w_fifo_empty && resp_ready);
  assign w_fifo_pop  = w_pop && !w_fifo_empty;

  dtim_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_fifo_push),
    .i_wdata ({w_po_err, w_po_rdata}),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign resp_valid              = !w_fifo_empty || w_po_valid;
  assign {resp_err, resp_rdata}  = w_fifo_empty ? {w_po_err, w_po_rdata} : w_fifo_head;

  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_dtim_pipelined.sv
// Directed bench: default DTIM (OUT_REG=0, RESP_DEPTH=2) plus a registered-output instance.
module tb_dtim_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [13:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata, resp_rdata;

  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic [13:0] b_req_addr;
  logic [3:0]  b_req_wmask;
  logic [31:0] b_req_wdata, b_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dtim_pipelined u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dtim_pipelined #(
    .OUT_REG    (1),
    .RESP_DEPTH (3)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_addr   (b_req_addr),
    .req_wmask  (b_req_wmask),
    .req_wdata  (b_req_wdata),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the default instance with resp_ready high; response due next cycle.
  task automatic txn(input string tag, input logic [13:0] a, input logic [3:0] m,
                     input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    check({tag, "_idle"}, resp_valid, 1'b0);
    check({tag, "_rdy"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_wmask = 4'h0;
    check({tag, "_vld"}, resp_valid, 1'b1);
    check({tag, "_data"}, resp_rdata, exp_d);
    check({tag, "_err"}, resp_err, exp_e);
  endtask

  // Four back-to-back requests on the OUT_REG=1 instance; responses at k+2, no bubbles.
  task automatic run_b(input logic wr);
    logic [13:0] addrs [4];
    logic [31:0] datas [4];
    addrs = '{14'h000, 14'h004, 14'h100, 14'h3FFC & 14'h0FFC};
    datas = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 6) begin
        check("b_vld", b_resp_valid, 1'b1);
        check("b_data", b_resp_rdata, datas[i-2]);
        check("b_err", b_resp_err, 1'b0);
      end else begin
        check("b_idle", b_resp_valid, 1'b0);
      end
      if (i < 4) begin
        check("b_rdy", b_req_ready, 1'b1);
        b_req_valid = 1'b1;
        b_req_addr  = addrs[i];
        b_req_wmask = wr ? 4'hF : 4'h0;
        b_req_wdata = wr ? datas[i] : 32'h0;
      end else begin
        b_req_valid = 1'b0;
        b_req_wmask = 4'h0;
      end
    end
  endtask

  initial begin
    logic [13:0] bp_addr [3];
    int          n_acc;
    bp_addr = '{14'h010, 14'h020, 14'h000};
    req_valid = 0; req_addr = '0; req_wmask = '0; req_wdata = '0; resp_ready = 1;
    b_req_valid = 0; b_req_addr = '0; b_req_wmask = '0; b_req_wdata = '0; b_resp_ready = 1;

    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", resp_err, 1'b0);
    rst = 1'b1;
    #1;
    check("rel_ready", req_ready, 1'b1);

    txn("wr010", 14'h010, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    txn("rd010", 14'h010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("wr020", 14'h020, 4'hF, 32'h1122_3344, 32'h1122_3344, 1'b0);
    txn("lane2", 14'h020, 4'b0100, 32'h00AA_0000, 32'h11AA_3344, 1'b0);
    txn("rd020", 14'h020, 4'h0, 32'h0, 32'h11AA_3344, 1'b0);
    txn("wr000", 14'h000, 4'hF, 32'h0123_4567, 32'h0123_4567, 1'b0);
    txn("rd_oor", 14'h1000, 4'h0, 32'h0, 32'h0, 1'b1);
    txn("wr_oor", 14'h1000, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1);
    txn("rd000", 14'h000, 4'h0, 32'h0, 32'h0123_4567, 1'b0);
    txn("last", 14'h0FFC, 4'hF, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0);
    txn("top_oor", 14'h3FFC, 4'h0, 32'h0, 32'h0, 1'b1);

    // Backpressure: credits cap outstanding requests at RESP_DEPTH.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = bp_addr[n_acc];
      if (req_ready) n_acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accepts", n_acc, 2);
    check("bp_ready0", req_ready, 1'b0);
    check("bp_vld", resp_valid, 1'b1);
    check("bp_head", resp_rdata, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    check("bp_stable", resp_rdata, 32'hDEAD_BEEF);
    resp_ready = 1'b1;
    check("bp_pop1_rdy", req_ready, 1'b0);
    @(negedge clk);
    check("bp_ready1", req_ready, 1'b1);
    check("bp_vld2", resp_valid, 1'b1);
    check("bp_data2", resp_rdata, 32'h11AA_3344);
    @(negedge clk);
    check("bp_drain", resp_valid, 1'b0);

    // Mid-operation reset with two responses outstanding.
    @(negedge clk);
    resp_ready = 1'b0;
    check("mr_rdy0", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = 14'h040; req_wmask = 4'hF; req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("mr_rdy1", req_ready, 1'b1);
    req_addr = 14'h010; req_wmask = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    check("mr_vld", resp_valid, 1'b1);
    check("mr_full", req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mr_flush", resp_valid, 1'b0);
    check("mr_rdy_rst", req_ready, 1'b0);
    rst = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("mr_rdy_rel", req_ready, 1'b1);
    txn("mr_rd040", 14'h040, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0);

    run_b(1'b1);
    run_b(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
